// File: rtl/qpu_exu_oitf.sv
// Outstanding-instruction tracking FIFO (OITF) for the QPU execution unit.
// It records long-pipe instructions in flight so dispatch can detect RAW/WAW
// register hazards and qubit-flag overlaps. A separate small FIFO (MOITF)
// tracks the qubit lists of measurements whose results have not returned.

`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 6
`endif

module qpu_exu_oitf #(
  parameter int unsigned OITF_DEPTH  = 4,
  parameter int unsigned MOITF_DEPTH = 2,
  parameter int unsigned RFIDX_W     = `QPU_RFIDX_REAL_WIDTH,
  parameter int unsigned QUBIT_NUM   = `QPU_QUBIT_NUM
) (
  input  logic                 clk,
  input  logic                 rst_n,

  // Dispatch-side allocation and hazard query
  input  logic                 i_disp_oitf_ena,
  output logic                 o_disp_oitf_ready,
  input  logic                 i_disp_oitf_rs1en,
  input  logic                 i_disp_oitf_rs2en,
  input  logic                 i_disp_oitf_rdwen,
  input  logic                 i_disp_oitf_qfren,
  input  logic [RFIDX_W-1:0]   i_disp_oitf_rs1idx,
  input  logic [RFIDX_W-1:0]   i_disp_oitf_rs2idx,
  input  logic [RFIDX_W-1:0]   i_disp_oitf_rdidx,
  input  logic [QUBIT_NUM-1:0] i_disp_oitf_qubitlist,
  output logic                 o_oitfrd_match_disprs1,
  output logic                 o_oitfrd_match_disprs2,
  output logic                 o_oitfrd_match_disprd,
  output logic                 o_oitfqf_match_dispql,

  // Long-pipe writeback retire
  input  logic                 i_oitf_ret_ena,
  output logic                 o_oitf_ret_rdwen,
  output logic [RFIDX_W-1:0]   o_oitf_ret_rdidx,
  output logic [QUBIT_NUM-1:0] o_oitf_ret_qubitlist,
  output logic                 o_oitf_empty,

  // Measurement tracking; the pushed list is the dispatching qubit list
  input  logic                 i_disp_moitf_ena,
  output logic                 o_disp_moitf_ready,
  input  logic                 i_moitf_ret_ena,
  output logic [QUBIT_NUM-1:0] o_moitf_ret_qubitlist,
  output logic                 o_moitf_empty
);

  localparam int unsigned AW  = $clog2(OITF_DEPTH);
  localparam int unsigned MAW = $clog2(MOITF_DEPTH);

  // Pointers carry the index in the low bits and the wrap flag in the MSB, so
  // a plain increment moves DEPTH-1 -> 0 and toggles the flag in one step.
  localparam logic [AW:0]  PtrOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [MAW:0] MPtrOne = {{MAW{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // OITF storage and pointers
  // ---------------------------------------------------------------------------
  logic [OITF_DEPTH-1:0] r_valid;
  logic                  r_rdwen [OITF_DEPTH];
  logic                  r_qfren [OITF_DEPTH];
  logic [RFIDX_W-1:0]    r_rdidx [OITF_DEPTH];
  logic [QUBIT_NUM-1:0]  r_qlist [OITF_DEPTH];
  logic [AW:0]           r_alloc_ptr;
  logic [AW:0]           r_ret_ptr;

  logic [AW-1:0]         w_alloc_idx;
  logic [AW-1:0]         w_ret_idx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_alloc;
  logic                  w_ret;

  assign w_alloc_idx = r_alloc_ptr[AW-1:0];
  assign w_ret_idx   = r_ret_ptr[AW-1:0];
  assign w_empty     = (r_alloc_ptr == r_ret_ptr);
  assign w_full      = (w_alloc_idx == w_ret_idx) && (r_alloc_ptr[AW] != r_ret_ptr[AW]);

  // Ready depends on registered state only; a same-cycle retire does not free a slot.
  assign w_alloc = i_disp_oitf_ena && !w_full;
  assign w_ret   = i_oitf_ret_ena && !w_empty;

  assign o_disp_oitf_ready = !w_full;
  assign o_oitf_empty      = w_empty;

  // Allocate at the tail, retire from the head; both may fire in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_alloc_ptr <= '0;
      r_ret_ptr   <= '0;
      for (int unsigned i = 0; i < OITF_DEPTH; i++) begin
        r_rdwen[i] <= 1'b0;
        r_qfren[i] <= 1'b0;
        r_rdidx[i] <= '0;
        r_qlist[i] <= '0;
      end
    end else begin
      if (w_alloc) begin
        r_valid[w_alloc_idx] <= 1'b1;
        r_rdwen[w_alloc_idx] <= i_disp_oitf_rdwen;
        r_qfren[w_alloc_idx] <= i_disp_oitf_qfren;
        r_rdidx[w_alloc_idx] <= i_disp_oitf_rdidx;
        r_qlist[w_alloc_idx] <= i_disp_oitf_qubitlist;
        r_alloc_ptr          <= r_alloc_ptr + PtrOne;
      end
      // Head and tail indices only coincide when empty (retire blocked) or
      // full (allocate blocked), so these two writes never collide.
      if (w_ret) begin
        r_valid[w_ret_idx] <= 1'b0;
        r_ret_ptr          <= r_ret_ptr + PtrOne;
      end
    end
  end

  // Head entry fields; meaningless while empty.
  assign o_oitf_ret_rdwen     = r_rdwen[w_ret_idx];
  assign o_oitf_ret_rdidx     = r_rdidx[w_ret_idx];
  assign o_oitf_ret_qubitlist = r_qlist[w_ret_idx];

  // ---------------------------------------------------------------------------
  // Hazard matching against registered valid entries (no allocate bypass)
  // ---------------------------------------------------------------------------
  logic w_hit_rs1;
  logic w_hit_rs2;
  logic w_hit_rd;
  logic w_hit_ql;

  // Scan every valid entry for register and qubit-list overlap.
  always_comb begin
    w_hit_rs1 = 1'b0;
    w_hit_rs2 = 1'b0;
    w_hit_rd  = 1'b0;
    w_hit_ql  = 1'b0;
    for (int unsigned i = 0; i < OITF_DEPTH; i++) begin
      if (r_valid[i] && r_rdwen[i]) begin
        if (r_rdidx[i] == i_disp_oitf_rs1idx) w_hit_rs1 = 1'b1;
        if (r_rdidx[i] == i_disp_oitf_rs2idx) w_hit_rs2 = 1'b1;
        if (r_rdidx[i] == i_disp_oitf_rdidx)  w_hit_rd  = 1'b1;
      end
      if (r_valid[i] && r_qfren[i] && |(r_qlist[i] & i_disp_oitf_qubitlist)) begin
        w_hit_ql = 1'b1;
      end
    end
  end

  assign o_oitfrd_match_disprs1 = w_hit_rs1 && i_disp_oitf_rs1en;
  assign o_oitfrd_match_disprs2 = w_hit_rs2 && i_disp_oitf_rs2en;
  assign o_oitfrd_match_disprd  = w_hit_rd  && i_disp_oitf_rdwen;
  assign o_oitfqf_match_dispql  = w_hit_ql  && i_disp_oitf_qfren;

  // ---------------------------------------------------------------------------
  // MOITF: qubit lists of outstanding measurements
  // ---------------------------------------------------------------------------
  logic [QUBIT_NUM-1:0] r_mlist [MOITF_DEPTH];
  logic [MAW:0]         r_mpush_ptr;
  logic [MAW:0]         r_mpop_ptr;

  logic [MAW-1:0]       w_mpush_idx;
  logic [MAW-1:0]       w_mpop_idx;
  logic                 w_mfull;
  logic                 w_mempty;
  logic                 w_mpush;
  logic                 w_mpop;

  assign w_mpush_idx = r_mpush_ptr[MAW-1:0];
  assign w_mpop_idx  = r_mpop_ptr[MAW-1:0];
  assign w_mempty    = (r_mpush_ptr == r_mpop_ptr);
  assign w_mfull     = (w_mpush_idx == w_mpop_idx) && (r_mpush_ptr[MAW] != r_mpop_ptr[MAW]);
  assign w_mpush     = i_disp_moitf_ena && !w_mfull;
  assign w_mpop      = i_moitf_ret_ena && !w_mempty;

  assign o_disp_moitf_ready    = !w_mfull;
  assign o_moitf_empty         = w_mempty;
  assign o_moitf_ret_qubitlist = r_mlist[w_mpop_idx];

  // Push measured qubit lists at the tail, pop on result return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mpush_ptr <= '0;
      r_mpop_ptr  <= '0;
      for (int unsigned i = 0; i < MOITF_DEPTH; i++) begin
        r_mlist[i] <= '0;
      end
    end else begin
      if (w_mpush) begin
        r_mlist[w_mpush_idx] <= i_disp_oitf_qubitlist;
        r_mpush_ptr          <= r_mpush_ptr + MPtrOne;
      end
      if (w_mpop) begin
        r_mpop_ptr <= r_mpop_ptr + MPtrOne;
      end
    end
  end

endmodule

// File: tb/tb_qpu_exu_oitf.sv
// Directed bench for qpu_exu_oitf: an occupancy model plus scoreboard queues
// predict ready/empty and the retiring head fields of both FIFOs.

`ifndef QPU_RFIDX_REAL_WIDTH
`define QPU_RFIDX_REAL_WIDTH 5
`endif
`ifndef QPU_QUBIT_NUM
`define QPU_QUBIT_NUM 6
`endif

module tb_qpu_exu_oitf;

  localparam int DEPTH  = 4;
  localparam int MDEPTH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       disp_ena = 1'b0;
  logic       disp_ready;
  logic       rs1en = 1'b0, rs2en = 1'b0, rdwen = 1'b0, qfren = 1'b0;
  logic [4:0] rs1idx = '0, rs2idx = '0, rdidx = '0;
  logic [5:0] qlist = '0;
  logic       m_rs1, m_rs2, m_rd, m_ql;
  logic       ret_ena = 1'b0;
  logic       ret_rdwen;
  logic [4:0] ret_rdidx;
  logic [5:0] ret_qlist;
  logic       oitf_empty;
  logic       mdisp_ena = 1'b0;
  logic       mready;
  logic       mret_ena = 1'b0;
  logic [5:0] mret_qlist;
  logic       moitf_empty;

  int         n_tests = 0;
  int         n_fail = 0;
  int         cnt = 0;
  int         mcnt = 0;
  logic [4:0] sb_rd[$];
  logic [5:0] sb_ml[$];

  qpu_exu_oitf #(
    .OITF_DEPTH (DEPTH),
    .MOITF_DEPTH(MDEPTH)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_disp_oitf_ena       (disp_ena),
    .o_disp_oitf_ready     (disp_ready),
    .i_disp_oitf_rs1en     (rs1en),
    .i_disp_oitf_rs2en     (rs2en),
    .i_disp_oitf_rdwen     (rdwen),
    .i_disp_oitf_qfren     (qfren),
    .i_disp_oitf_rs1idx    (rs1idx),
    .i_disp_oitf_rs2idx    (rs2idx),
    .i_disp_oitf_rdidx     (rdidx),
    .i_disp_oitf_qubitlist (qlist),
    .o_oitfrd_match_disprs1(m_rs1),
    .o_oitfrd_match_disprs2(m_rs2),
    .o_oitfrd_match_disprd (m_rd),
    .o_oitfqf_match_dispql (m_ql),
    .i_oitf_ret_ena        (ret_ena),
    .o_oitf_ret_rdwen      (ret_rdwen),
    .o_oitf_ret_rdidx      (ret_rdidx),
    .o_oitf_ret_qubitlist  (ret_qlist),
    .o_oitf_empty          (oitf_empty),
    .i_disp_moitf_ena      (mdisp_ena),
    .o_disp_moitf_ready    (mready),
    .i_moitf_ret_ena       (mret_ena),
    .o_moitf_ret_qubitlist (mret_qlist),
    .o_moitf_empty         (moitf_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One OITF cycle: model predicts ready/empty and the head being retired.
  task automatic ocycle(input bit alloc, input logic [4:0] rd, input bit qf,
                        input logic [5:0] ql, input bit ret);
    bit a, r;
    disp_ena = alloc; rdwen = alloc; rdidx = rd; qfren = qf; qlist = ql; ret_ena = ret;
    #1;
    check("oitf_ready", disp_ready, (cnt < DEPTH));
    check("oitf_empty", oitf_empty, (cnt == 0));
    a = alloc && (cnt < DEPTH);
    r = ret && (cnt > 0);
    if (r) begin
      if (sb_rd.size() == 0) check("sb_underflow", 1, 0);
      else check("ret_rdidx", ret_rdidx, sb_rd.pop_front());
    end
    if (a) sb_rd.push_back(rd);
    cnt = cnt + int'(a) - int'(r);
    tick();
    disp_ena = 1'b0; rdwen = 1'b0; qfren = 1'b0; qlist = '0; ret_ena = 1'b0;
  endtask

  // One MOITF cycle; the pushed list comes from the dispatch qubit list.
  task automatic mcycle(input bit push, input logic [5:0] ql, input bit pop);
    bit a, r;
    mdisp_ena = push; qlist = ql; mret_ena = pop;
    #1;
    check("moitf_ready", mready, (mcnt < MDEPTH));
    check("moitf_empty", moitf_empty, (mcnt == 0));
    a = push && (mcnt < MDEPTH);
    r = pop && (mcnt > 0);
    if (r) begin
      if (sb_ml.size() == 0) check("msb_underflow", 1, 0);
      else check("moitf_ret_ql", mret_qlist, sb_ml.pop_front());
    end
    if (a) sb_ml.push_back(ql);
    mcnt = mcnt + int'(a) - int'(r);
    tick();
    mdisp_ena = 1'b0; mret_ena = 1'b0; qlist = '0;
  endtask

  initial begin
    // Reset state, with hazard enables raised against an empty table
    rs1en = 1'b1; rs2en = 1'b1; rdwen = 1'b1; qfren = 1'b1; qlist = 6'b111111;
    #12;
    check("rst_oitf_empty", oitf_empty, 1);
    check("rst_moitf_empty", moitf_empty, 1);
    check("rst_ready", disp_ready, 1);
    check("rst_mready", mready, 1);
    check("rst_matches", {m_rs1, m_rs2, m_rd, m_ql}, 4'b0000);
    rs1en = 1'b0; rs2en = 1'b0; rdwen = 1'b0; qfren = 1'b0; qlist = '0;
    rst_n = 1'b1;
    tick();

    // RAW hazard on rd=3; no bypass while the allocation is still in flight
    rs1idx = 5'd3; rs1en = 1'b1;
    disp_ena = 1'b1; rdwen = 1'b1; rdidx = 5'd3;
    #1;
    check("no_bypass_rs1", m_rs1, 0);
    sb_rd.push_back(5'd3); cnt = 1;
    tick();
    disp_ena = 1'b0; rdwen = 1'b0;
    check("raw_rs1", m_rs1, 1);
    rs1en = 1'b0; #1;
    check("raw_rs1_off", m_rs1, 0);
    rs2idx = 5'd3; rs2en = 1'b1; #1;
    check("raw_rs2", m_rs2, 1);
    rs2idx = 5'd4; #1;
    check("raw_rs2_other", m_rs2, 0);
    rs2en = 1'b0;
    rdidx = 5'd3; rdwen = 1'b1; #1;
    check("waw_rd", m_rd, 1);
    check("ret_rdwen", ret_rdwen, 1);
    // Entry retiring this cycle still matches this cycle
    ret_ena = 1'b1; rs1en = 1'b1; #1;
    check("retiring_match", m_rs1, 1);
    ret_ena = 1'b0; rdwen = 1'b0;
    ocycle(0, 5'd0, 0, 6'd0, 1);
    rs1en = 1'b1; #1;
    check("retired_no_match", m_rs1, 0);
    rs1en = 1'b0;

    // Qubit-list overlap
    ocycle(1, 5'd9, 1, 6'b001100, 0);
    qfren = 1'b1; qlist = 6'b000100; #1;
    check("ql_overlap", m_ql, 1);
    check("ret_qlist", ret_qlist, 6'b001100);
    qlist = 6'b010000; #1;
    check("ql_disjoint", m_ql, 0);
    qfren = 1'b0; qlist = 6'b000100; #1;
    check("ql_qfren_off", m_ql, 0);
    ocycle(0, 5'd0, 0, 6'd0, 1);

    // Fill to full, ignored fifth allocation, retire reopens
    for (int i = 0; i < 4; i++) ocycle(1, 5'(10 + i), 0, 6'd0, 0);
    ocycle(1, 5'd20, 0, 6'd0, 0);
    ocycle(0, 5'd0, 0, 6'd0, 1);
    check("ready_after_ret", disp_ready, 1);
    check("head_is_2nd", ret_rdidx, 5'd11);
    ocycle(1, 5'd14, 0, 6'd0, 0);

    // Full: allocate+retire together retires only; then drain
    ocycle(1, 5'd21, 0, 6'd0, 1);
    check("occ3_ready", disp_ready, 1);
    for (int i = 0; i < 3; i++) ocycle(0, 5'd0, 0, 6'd0, 1);
    // Retire while empty is ignored
    ocycle(0, 5'd0, 0, 6'd0, 1);
    ocycle(0, 5'd0, 0, 6'd0, 0);
    ocycle(1, 5'd7, 0, 6'd0, 0);
    ocycle(0, 5'd0, 0, 6'd0, 1);

    // Ten alloc/retire pairs, wrapping both pointers
    ocycle(1, 5'd1, 0, 6'd0, 0);
    for (int i = 2; i <= 10; i++) ocycle(1, 5'(i), 0, 6'd0, 1);
    ocycle(0, 5'd0, 0, 6'd0, 1);
    check("wrap_end_empty", oitf_empty, 1);

    // MOITF: push two, full, extra push ignored, pops in order, pop-while-empty
    mcycle(1, 6'b000010, 0);
    mcycle(1, 6'b001000, 0);
    mcycle(1, 6'b111111, 0);
    mcycle(1, 6'b000001, 1);
    mcycle(0, 6'd0, 1);
    mcycle(1, 6'b100000, 1);
    mcycle(0, 6'd0, 1);
    mcycle(0, 6'd0, 1);
    mcycle(0, 6'd0, 0);

    // Mid-cycle asynchronous reset discards everything
    mcycle(1, 6'b000010, 0);
    mcycle(1, 6'b001000, 0);
    ocycle(1, 5'd6, 0, 6'd0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_moitf_empty", moitf_empty, 1);
    check("arst_mready", mready, 1);
    check("arst_oitf_empty", oitf_empty, 1);
    rs1idx = 5'd6; rs1en = 1'b1; #1;
    check("arst_no_match", m_rs1, 0);
    rs1en = 1'b0;
    sb_rd.delete(); sb_ml.delete(); cnt = 0; mcnt = 0;
    #1;
    rst_n = 1'b1;
    tick();
    ocycle(1, 5'd5, 0, 6'd0, 0);
    check("post_rst_head", ret_rdidx, 5'd5);
    ocycle(0, 5'd0, 0, 6'd0, 1);
    mcycle(1, 6'b010101, 0);
    mcycle(0, 6'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/qpu_exu_oitf.md
QPU_EXU_OITF -- requirements
Module: QPU_exu_oitf

Interface
REQ-001 Parameter OITF_DEPTH, default 4, meaning: outstanding-instruction entries, power of two >= 2.
REQ-002 Parameter MOITF_DEPTH, default 2, meaning: outstanding-measure entries, power of two >= 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk input 1 is the rising-edge clock, and rst_n input 1 is the asynchronous active-low reset.
REQ-004 disp_oitf_ena  input  1  allocate request from dispatch.
REQ-005 disp_oitf_ready  output  1  OITF can accept an allocation.
REQ-006 disp_oitf_rs1en / disp_oitf_rs2en / disp_oitf_rdwen / disp_oitf_qfren  input  1 each  operand enables, rd write, qubit-flag read.
REQ-007 disp_oitf_rs1idx / disp_oitf_rs2idx / disp_oitf_rdidx  input  `QPU_RFIDX_REAL_WIDTH each  register indices.
REQ-008 disp_oitf_qubitlist  input  `QPU_QUBIT_NUM  qubits touched by dispatching instruction.
REQ-009 oitfrd_match_disprs1 / oitfrd_match_disprs2 / oitfrd_match_disprd  output  1 each  RAW/WAW hazard flags.
REQ-010 oitfqf_match_dispql  output  1  qubit-list overlap with an outstanding qfren entry.
REQ-011 oitf_ret_ena  input  1  retire oldest OITF entry (long-pipe writeback).
REQ-012 oitf_ret_rdwen / oitf_ret_rdidx / oitf_ret_qubitlist  output  1 / RFIDX / QUBIT_NUM  oldest entry fields.
REQ-013 oitf_empty  output  1  no OITF entry valid.
REQ-014 disp_moitf_ena  input  1  push measure qubit list; disp_moitf_ready  output  1  measure FIFO not full.
REQ-015 moitf_ret_ena  input  1  measurement result returned; moitf_ret_qubitlist  output  QUBIT_NUM  oldest measure list; moitf_empty  output  1.

Function
REQ-016 OITF SHALL be an in-order circular FIFO; alloc_ptr and ret_ptr each log2(OITF_DEPTH) bits plus one wrap flag.
REQ-017 Allocation fires when disp_oitf_ena && disp_oitf_ready: entry[alloc_ptr] stores rdwen, rdidx, qfren, qubitlist; valid set; alloc_ptr increments at the next edge.
REQ-018 Retire fires when oitf_ret_ena && !oitf_empty: valid[ret_ptr] cleared; ret_ptr increments; oitf_ret_ena while empty SHALL be ignored.
REQ-019 Pointer wrap: index DEPTH-1 -> 0 toggles that pointer's wrap flag.
REQ-020 oitf_empty = pointers equal and flags equal; full = indices equal and flags differ; disp_oitf_ready = !full (state only, not same-cycle retire).
REQ-021 Simultaneous allocate and retire (not full, not empty) SHALL both take effect; occupancy unchanged.
REQ-022 oitfrd_match_disprs1 = OR over valid entries of (rdwen && rdidx == disp_oitf_rs1idx) && disp_oitf_rs1en; rs2 likewise with rs2en.
REQ-023 oitfrd_match_disprd = OR over valid entries of (rdwen && rdidx == disp_oitf_rdidx) && disp_oitf_rdwen.
REQ-024 oitfqf_match_dispql = OR over valid entries with qfren of |(qubitlist & disp_oitf_qubitlist) — and disp_oitf_qfren.
REQ-025 All match outputs SHALL be combinational from registered valid state only: no bypass of a same-cycle allocation; an entry retiring this cycle still matches this cycle.
REQ-026 oitf_ret_* SHALL present entry[ret_ptr] fields combinationally; value is don't-care when empty.
REQ-027 MOITF SHALL be an independent circular FIFO of qubit lists with identical pointer, full, empty, wrap and simultaneous push/pop rules; disp_moitf_ready = !mfull.
REQ-028 A push while full or a pop while empty SHALL leave all state unchanged.

Reset
REQ-029 On rst_n low, asynchronously: all valid bits 0, all pointers and wrap flags 0; oitf_empty=1, moitf_empty=1, disp_oitf_ready=1, disp_moitf_ready=1, all match outputs 0.
REQ-030 Reset asserted mid-operation SHALL discard all outstanding entries; first edge after release behaves as post-reset.

Verification
REQ-031 Allocate rdidx=3 rdwen=1, next cycle rs1idx=3 rs1en=1 -> oitfrd_match_disprs1=1; with rs1en=0 -> 0.
REQ-032 Four allocations with no retire -> disp_oitf_ready=0 after 4th; 5th ena ignored; one retire -> ready=1 next cycle, ret_rdidx = 2nd entry's rdidx.
REQ-033 Full FIFO, retire and ena same cycle -> retire only, occupancy 3; empty FIFO, retire alone -> no pointer change, oitf_empty stays 1.
REQ-034 Allocate qfren=1 qubitlist=6'b001100; dispatch qubitlist=6'b000100 qfren=1 -> oitfqf_match_dispql=1; 6'b010000 -> 0.
REQ-035 Cycle 10 alloc/retire pairs through depth 4 -> pointers wrap twice, flags toggle, FIFO order preserved, empty=1 at end.
REQ-036 Push two measure lists (6'b000010, 6'b001000), assert rst_n low mid-cycle -> moitf_empty=1 immediately, disp_moitf_ready=1.
